// File: rtl/sdram_mon_pkg.sv
// Shared types for the SDRAM power-up sequence monitor: command, state and
// error-code enums plus default parameter values.
package sdram_mon_pkg;

  localparam int unsigned DEF_INIT_CYCLES    = 5000;
  localparam int unsigned DEF_PRE_WINDOW     = 8;
  localparam int unsigned DEF_NUM_AREF       = 2;
  localparam int unsigned DEF_TRFC_CYCLES    = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    CMD_INHIBIT = 3'd0,
    CMD_NOP     = 3'd1,
    CMD_ACTIVE  = 3'd2,
    CMD_AREF    = 3'd3,
    CMD_PRE     = 3'd4,
    CMD_LMR     = 3'd5,
    CMD_OTHER   = 3'd6
  } cmd_e;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'd0,
    ST_PRE_WIN = 3'd1,
    ST_AREF    = 3'd2,
    ST_LMR     = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_EARLY_CMD   = 3'd1,
    ERR_NO_PRE      = 3'd2,
    ERR_PRE_NOT_ALL = 3'd3,
    ERR_ORDER       = 3'd4,
    ERR_TRFC        = 3'd5,
    ERR_TIMEOUT     = 3'd6
  } err_e;

endpackage

// File: rtl/sdram_cmd_decode.sv
// Combinational decode of the SDRAM command pins {cs_n,ras_n,cas_n,we_n}.
module sdram_cmd_decode
  import sdram_mon_pkg::*;
(
  input  logic i_cs_n,
  input  logic i_ras_n,
  input  logic i_cas_n,
  input  logic i_we_n,
  output cmd_e o_cmd
);

  always_comb begin
    o_cmd = CMD_OTHER;
    if (i_cs_n) begin
      o_cmd = CMD_INHIBIT;
    end else begin
      case ({i_ras_n, i_cas_n, i_we_n})
        3'b111:  o_cmd = CMD_NOP;
        3'b011:  o_cmd = CMD_ACTIVE;
        3'b001:  o_cmd = CMD_AREF;
        3'b010:  o_cmd = CMD_PRE;
        3'b000:  o_cmd = CMD_LMR;
        default: o_cmd = CMD_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/sdram_init_monitor.sv
// Checks the SDRAM power-up sequence: idle wait, PRECHARGE-all, N x AREF, LMR.
// Optional PRE-to-LMR watchdog is enabled by defining SDRAM_INIT_MON_TIMEOUT_EN.
module sdram_init_monitor
  import sdram_mon_pkg::*;
#(
  parameter int unsigned INIT_CYCLES    = DEF_INIT_CYCLES,
  parameter int unsigned PRE_WINDOW     = DEF_PRE_WINDOW,
  parameter int unsigned NUM_AREF       = DEF_NUM_AREF,
  parameter int unsigned TRFC_CYCLES    = DEF_TRFC_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       ras_n,
  input  logic       cas_n,
  input  logic       we_n,
  input  logic       a10,
  output logic       init_done,
  output logic       done_pulse,
  output logic       init_err,
  output logic [2:0] err_code,
  output logic [2:0] state
);

  localparam int unsigned CNT_MAX = (INIT_CYCLES > PRE_WINDOW) ? INIT_CYCLES : PRE_WINDOW;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned AW = $clog2(NUM_AREF + 1);
  localparam int unsigned GW = $clog2(TRFC_CYCLES + 1);

  cmd_e   w_cmd;
  logic   w_idle;
  err_e   w_err;
  state_e r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_aref_cnt;
  logic [GW-1:0] r_gap;
  logic   r_done, r_pulse, r_err;
  err_e   r_code;

  sdram_cmd_decode u_dec (
    .i_cs_n (cs_n),
    .i_ras_n(ras_n),
    .i_cas_n(cas_n),
    .i_we_n (we_n),
    .o_cmd  (w_cmd)
  );

  assign w_idle = (w_cmd == CMD_INHIBIT) || (w_cmd == CMD_NOP);

`ifdef SDRAM_INIT_MON_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wdog;
  logic          w_wdog_hit;
  // A completing LMR on the limit cycle still counts as success.
  assign w_wdog_hit = ((r_state == ST_AREF) ||
                       (r_state == ST_LMR && w_cmd != CMD_LMR)) &&
                      (r_wdog == WW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    w_err = ERR_NONE;
    case (r_state)
      ST_WAIT: if (!w_idle) w_err = ERR_EARLY_CMD;
      ST_PRE_WIN: begin
        if (w_cmd == CMD_PRE) begin
          if (!a10) w_err = ERR_PRE_NOT_ALL;
        end else if (!w_idle) begin
          w_err = ERR_ORDER;
        end else if (r_cnt == CW'(PRE_WINDOW - 1)) begin
          w_err = ERR_NO_PRE;
        end
      end
      ST_AREF: begin
        // r_gap holds cycles since the previous AREF issue, saturating at tRFC.
        if (w_cmd == CMD_AREF) begin
          if (r_aref_cnt != '0 && r_gap < GW'(TRFC_CYCLES)) w_err = ERR_TRFC;
        end else if (!w_idle) begin
          w_err = ERR_ORDER;
        end
      end
      ST_LMR: if (w_cmd != CMD_LMR && !w_idle) w_err = ERR_ORDER;
      default: ;
    endcase
`ifdef SDRAM_INIT_MON_TIMEOUT_EN
    if (w_err == ERR_NONE && w_wdog_hit) w_err = ERR_TIMEOUT;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_WAIT;
      r_cnt      <= '0;
      r_aref_cnt <= '0;
      r_gap      <= '0;
      r_done     <= 1'b0;
      r_pulse    <= 1'b0;
      r_err      <= 1'b0;
      r_code     <= ERR_NONE;
    end else begin
      r_pulse <= 1'b0;
      if (w_err != ERR_NONE) begin
        r_state <= ST_ERROR;
        r_err   <= 1'b1;
        r_code  <= w_err;
      end else begin
        case (r_state)
          ST_WAIT: begin
            if (r_cnt == CW'(INIT_CYCLES - 1)) begin
              r_state <= ST_PRE_WIN;
              r_cnt   <= '0;
            end else if (r_cnt != CW'(CNT_MAX)) begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          ST_PRE_WIN: begin
            if (w_cmd == CMD_PRE) begin
              r_state    <= ST_AREF;
              r_aref_cnt <= '0;
              r_gap      <= '0;
            end else if (r_cnt != CW'(CNT_MAX)) begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          ST_AREF: begin
            if (w_cmd == CMD_AREF) begin
              r_gap      <= GW'(1);
              r_aref_cnt <= r_aref_cnt + AW'(1);
              if (r_aref_cnt == AW'(NUM_AREF - 1)) r_state <= ST_LMR;
            end else if (r_gap != GW'(TRFC_CYCLES)) begin
              r_gap <= r_gap + GW'(1);
            end
          end
          ST_LMR: begin
            if (w_cmd == CMD_LMR) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_pulse <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SDRAM_INIT_MON_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset || (r_state == ST_PRE_WIN)) begin
      r_wdog <= '0;
    end else if ((r_state == ST_AREF || r_state == ST_LMR) &&
                 r_wdog != WW'(TIMEOUT_CYCLES)) begin
      r_wdog <= r_wdog + WW'(1);
    end
  end
`endif

  assign init_done  = r_done;
  assign done_pulse = r_pulse;
  assign init_err   = r_err;
  assign err_code   = r_code;
  assign state      = r_state;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Directed checks of the SDRAM init monitor with short timing parameters.
module tb_sdram_init_monitor;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_LMR = 4'b0000;

  localparam int S_WAIT = 0, S_PREW = 1, S_AREF = 2, S_LMR = 3, S_DONE = 4, S_ERR = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, a10 = 1'b0;
  logic       init_done, done_pulse, init_err;
  logic [2:0] err_code, state;

  int n_chk = 0;
  int n_fail = 0;

  always #10 clk = ~clk;

  sdram_init_monitor #(
    .INIT_CYCLES(16), .PRE_WINDOW(8), .NUM_AREF(2),
    .TRFC_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .a10(a10),
    .init_done(init_done), .done_pulse(done_pulse), .init_err(init_err),
    .err_code(err_code), .state(state)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic a);
    @(negedge clk);
    reset = 1'b0;
    {cs_n, ras_n, cas_n, we_n} = c;
    a10 = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int st, input int dn, input int pl,
                         input int er, input int code);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".done"}, int'(init_done), dn);
    chk({tag, ".pulse"}, int'(done_pulse), pl);
    chk({tag, ".err"}, int'(init_err), er);
    chk({tag, ".code"}, int'(err_code), code);
  endtask

  // Reset cycle carries an ACTIVE that must be ignored.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = C_ACT;
    @(posedge clk);
    #1;
    chk_all(tag, S_WAIT, 0, 0, 0, 0);
  endtask

  // Legal schedule: PRE-all at 18, AREF at 20 and 24, LMR at 27.
  task automatic legal(input int c);
    case (c)
      18:      step(C_PRE, 1'b1);
      20, 24:  step(C_REF, 1'b0);
      27:      step(C_LMR, 1'b0);
      default: step(C_NOP, 1'b0);
    endcase
  endtask

  initial begin
    do_reset("rst0");

    // Full legal sequence with state-boundary checks.
    for (int c = 0; c <= 27; c++) begin
      legal(c);
      if (c == 14) chk("wait_end", int'(state), S_WAIT);
      if (c == 15) chk("prewin_entry", int'(state), S_PREW);
      if (c == 18) chk("aref_entry", int'(state), S_AREF);
      if (c == 24) chk("lmr_entry", int'(state), S_LMR);
      if (c == 26) chk("not_done_yet", int'(init_done), 0);
    end
    chk_all("done", S_DONE, 1, 1, 0, 0);
    step(C_NOP, 1'b0);
    chk_all("done_hold", S_DONE, 1, 0, 0, 0);
    step(C_ACT, 1'b0);
    chk_all("done_terminal", S_DONE, 1, 0, 0, 0);
    do_reset("rst_after_done");

    // Early command during the idle wait.
    for (int c = 0; c < 5; c++) step(C_NOP, 1'b0);
    chk("pre_early", int'(init_err), 0);
    step(C_ACT, 1'b0);
    chk_all("early", S_ERR, 0, 0, 1, 1);
    step(C_PRE, 1'b0);
    chk("first_err_kept", int'(err_code), 1);
    do_reset("rst1");

    // PRECHARGE without a10 in the window.
    for (int c = 0; c < 18; c++) step(C_NOP, 1'b0);
    step(C_PRE, 1'b0);
    chk_all("pre_not_all", S_ERR, 0, 0, 1, 3);
    do_reset("rst2");

    // No PRECHARGE in the 8-cycle window (cycles 16..23).
    for (int c = 0; c <= 22; c++) step(C_NOP, 1'b0);
    chk("window_open", int'(init_err), 0);
    step(C_NOP, 1'b0);
    chk_all("no_pre", S_ERR, 0, 0, 1, 2);
    do_reset("rst3");

    // PRECHARGE in the last window slot is accepted.
    for (int c = 0; c <= 22; c++) step(C_NOP, 1'b0);
    step(C_PRE, 1'b1);
    chk_all("pre_last_slot", S_AREF, 0, 0, 0, 0);
    do_reset("rst4");

    // AREFs only two cycles apart.
    for (int c = 0; c <= 21; c++) legal(c);
    step(C_REF, 1'b0);
    chk_all("trfc", S_ERR, 0, 0, 1, 5);
    do_reset("rst5");

    // ACTIVE between refreshes.
    for (int c = 0; c <= 20; c++) legal(c);
    step(C_ACT, 1'b0);
    chk_all("order_aref", S_ERR, 0, 0, 1, 4);
    do_reset("rst6");

    // Extra AREF once the refresh count is met.
    for (int c = 0; c <= 24; c++) legal(c);
    step(C_REF, 1'b0);
    chk_all("extra_aref", S_ERR, 0, 0, 1, 4);
    do_reset("rst7");

    // Watchdog: PRE at 18, then 64 NOPs.
    for (int c = 0; c <= 18; c++) legal(c);
    for (int c = 19; c <= 81; c++) step(C_NOP, 1'b0);
    chk("wdog_before", int'(init_err), 0);
    step(C_NOP, 1'b0);
`ifdef SDRAM_INIT_MON_TIMEOUT_EN
    chk_all("wdog", S_ERR, 0, 0, 1, 6);
`else
    chk_all("no_wdog", S_AREF, 0, 0, 0, 0);
`endif
    do_reset("rst8");

    // Reset mid-sequence at cycle 10, then a full legal run.
    for (int c = 0; c <= 9; c++) legal(c);
    do_reset("rst_mid");
    for (int c = 0; c <= 27; c++) legal(c);
    chk_all("done_after_mid", S_DONE, 1, 1, 0, 0);
    do_reset("rst_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_init_monitor.md
SDRAM_INIT_MONITOR -- requirements
Module: sdram_init_monitor

Interface
REQ-001 Parameter INIT_CYCLES, default 5000, meaning mandatory NOP/INHIBIT cycles after reset (100 us at 20 ns clock).
REQ-002 Parameter PRE_WINDOW, default 8, meaning cycles after INIT_CYCLES in which PRECHARGE-all is accepted.
REQ-003 Parameter NUM_AREF, default 2, range 1..15, meaning required AUTO REFRESH count.
REQ-004 Parameter TRFC_CYCLES, default 4, meaning minimum cycles between consecutive AUTO REFRESH commands (issue to issue).
REQ-005 Parameter TIMEOUT_CYCLES, default 1024, meaning watchdog limit from PRECHARGE to LOAD MODE REG.
REQ-006 clk  input  1  single clock; all logic samples on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 cs_n, ras_n, cas_n, we_n  input  1 each  SDRAM command pins, sampled every cycle.
REQ-009 a10  input  1  SDRAM address bit 10; qualifies PRECHARGE as all-banks.
REQ-010 init_done  output  1  sticky; initialization sequence completed legally.
REQ-011 done_pulse  output  1  single-cycle pulse when init_done rises.
REQ-012 init_err  output  1  sticky; sequence violation detected.
REQ-013 err_code  output  3  first violation code (package enum); 0 = none.
REQ-014 state  output  3  current monitor state, for debug/coverage.

Function
REQ-015 Commands shall decode as: INHIBIT cs_n=1; NOP 0111; ACTIVE 0011; AREF 0001; PRE 0010; LMR 0000; anything else OTHER (columns cs_n ras_n cas_n we_n).
REQ-016 States shall be WAIT, PRE_WIN, AREF, LMR, DONE, ERROR; reset enters WAIT with cycle counter 0.
REQ-017 WAIT: counter increments each cycle; any command other than INHIBIT/NOP sets ERR_EARLY_CMD (1); at counter == INIT_CYCLES-1 move to PRE_WIN with counter cleared.
REQ-018 PRE_WIN: INHIBIT/NOP allowed; PRE with a10=1 moves to AREF; PRE with a10=0 sets ERR_PRE_NOT_ALL (3); any other command sets ERR_ORDER (4); counter reaching PRE_WINDOW without PRE sets ERR_NO_PRE (2).
REQ-019 AREF: refresh count and spacing counter start at 0; AREF increments count; AREF arriving fewer than TRFC_CYCLES cycles after the previous AREF sets ERR_TRFC (5); INHIBIT/NOP allowed; other commands set ERR_ORDER; count == NUM_AREF moves to LMR.
REQ-020 LMR: INHIBIT/NOP allowed; LMR moves to DONE; any other command (including extra AREF) sets ERR_ORDER.
REQ-021 Any error transition shall enter ERROR, assert init_err and latch err_code on the next edge; err_code holds the first error only until reset.
REQ-022 DONE and ERROR are terminal; commands are ignored; both init_done and init_err shall never be 1 simultaneously.
REQ-023 Latency: all outputs registered; init_done, done_pulse, init_err and err_code change exactly one cycle after the offending/completing command is sampled.
REQ-024 Counters shall be sized $clog2(max parameter + 1) and saturate, never wrap.

Reset
REQ-025 Reset asserted in any state, including mid-sequence, DONE or ERROR, shall on the next edge force state=WAIT, all counters 0, init_done=0, done_pulse=0, init_err=0, err_code=0.
REQ-026 Commands sampled in a cycle with reset=1 shall be ignored.

Configuration
REQ-027 Macro SDRAM_INIT_MON_TIMEOUT_EN defined: a watchdog counts from PRE acceptance; reaching TIMEOUT_CYCLES while in AREF or LMR sets ERR_TIMEOUT (6).
REQ-028 Macro undefined: no watchdog logic; code 6 never produced; AREF/LMR wait indefinitely.

Structure
REQ-029 Package sdram_mon_pkg shall hold the command enum, state enum, error-code enum and default parameter constants.
REQ-030 Sub-module sdram_cmd_decode shall map the four pins to the command enum combinationally; no other sub-modules.

Verification (bench: INIT_CYCLES=16, PRE_WINDOW=8, NUM_AREF=2, TRFC_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-031 16 NOP, PRE a10=1 at cycle 18, AREF at 20 and 24, LMR at 27 -> init_done=1 and done_pulse for one cycle at 28, err_code=0.
REQ-032 ACTIVE at cycle 5 -> init_err=1 at cycle 6, err_code=1, state=ERROR.
REQ-033 PRE with a10=0 in window -> err_code=3; NOP through cycle 24 with no PRE -> err_code=2.
REQ-034 AREF at 20 then AREF at 22 -> err_code=5; ACTIVE between AREFs -> err_code=4.
REQ-035 With SDRAM_INIT_MON_TIMEOUT_EN, PRE then NOP only for 64 cycles -> err_code=6; without macro -> state stays AREF, init_err=0.
REQ-036 Reset pulsed at cycle 10 of a legal sequence, and again after DONE -> all outputs 0, state=WAIT next cycle; full legal sequence then completes.
